// File: rtl/gcd_seq.sv
// Sequencer in front of a gcd core: takes operand pairs, pulses ld, waits for done
// (or times out), and queues {u, v, res, err} in a small result FIFO.
module gcd_seq #(
  parameter int W         = 8,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_u,
  input  logic [W-1:0] in_v,
  output logic         gcd_ld,
  output logic [W-1:0] gcd_u,
  output logic [W-1:0] gcd_v,
  input  logic [W-1:0] gcd_res,
  input  logic         gcd_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_u,
  output logic [W-1:0] out_v,
  output logic [W-1:0] out_res,
  output logic         out_err,
  output logic         busy
);

  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 3 * W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_PUSH = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_ld;
  logic [W-1:0]    r_u;
  logic [W-1:0]    r_v;
  logic [W-1:0]    r_res;
  logic            r_err;
  logic [TW-1:0]   r_timer;
  logic            r_done_q;

  logic [EW-1:0]   r_mem [RES_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_done_rise;
  logic [EW-1:0]   w_head;

  assign w_done_rise = gcd_done & ~r_done_q;
  // The FIFO slot is reserved at accept, so a later push can never overflow.
  assign in_ready    = (r_state == S_IDLE) && (r_count < CW'(RES_DEPTH));
  assign w_accept    = in_valid & in_ready;
  assign w_push      = (r_state == S_PUSH);
  assign w_pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ld     <= 1'b0;
      r_u      <= '0;
      r_v      <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_timer  <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= gcd_done;
      r_ld     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_u <= in_u;
            r_v <= in_v;
            if ((in_u == '0) || (in_v == '0)) begin
              r_res   <= in_u | in_v;
              r_err   <= 1'b0;
              r_state <= S_PUSH;
            end else begin
              r_ld    <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_done_rise) begin
            r_res   <= gcd_res;
            r_err   <= 1'b0;
            r_state <= S_PUSH;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_u, r_v, r_res, r_err};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_u     = out_valid ? w_head[EW-1 -: W]    : '0;
  assign out_v     = out_valid ? w_head[EW-1-W -: W]  : '0;
  assign out_res   = out_valid ? w_head[W:1]          : '0;
  assign out_err   = out_valid ? w_head[0]            : 1'b0;

  assign gcd_ld = r_ld;
  assign gcd_u  = r_u;
  assign gcd_v  = r_v;
  assign busy   = (r_state != S_IDLE);

endmodule
